// File: rtl/hist_dump_receiver.sv
// Histogram dump receiver: captures one NUM_BINS-beat frame, checks framing,
// tracks total and peak on the fly, and holds the results until the host acks.
module hist_dump_receiver #(
  parameter int NUM_BINS = 32,
  parameter int BIN_W    = 4,
  parameter int FCNT_W   = 8,
  parameter int IDX_W    = $clog2(NUM_BINS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [BIN_W-1:0]  bin_data,
  input  logic              bin_valid,
  input  logic              bin_last,
  input  logic              ack,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [BIN_W-1:0]  rd_data,
  output logic              frame_ready,
  output logic [BIN_W+IDX_W-1:0] total,
  output logic [BIN_W-1:0]  peak_val,
  output logic [IDX_W-1:0]  peak_idx,
  output logic              frame_err,
  output logic              overrun,
  output logic [FCNT_W-1:0] frame_cnt
);
  localparam int SUM_W = BIN_W + IDX_W;

  typedef enum logic [1:0] {CAPTURE, HOLD, DISCARD} state_t;

  state_t state, state_n;
  logic [IDX_W-1:0] cnt;
  logic [SUM_W-1:0] run_sum, sum_n;
  logic [BIN_W-1:0] run_peak, peak_n;
  logic [IDX_W-1:0] run_idx, idx_n;
  logic [NUM_BINS-1:0][BIN_W-1:0] bin_mem;

  logic at_end, cap_beat, good, err_set, drop;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n)   state <= CAPTURE;
    else if (ena) state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      CAPTURE: if (bin_valid && at_end) state_n = bin_last ? HOLD : DISCARD;
      HOLD:    if (ack) state_n = CAPTURE;
      DISCARD: if (bin_valid && bin_last) state_n = CAPTURE;
      default: state_n = CAPTURE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    at_end      = (cnt == IDX_W'(NUM_BINS-1));
    cap_beat    = bin_valid && (state == CAPTURE);
    good        = cap_beat && at_end && bin_last;
    err_set     = cap_beat && (at_end != bin_last);
    drop        = bin_valid && (state == HOLD);
    frame_ready = (state == HOLD);
  end

  // Running sum/peak as they would stand after this beat; beat 0 reloads
  always_comb begin
    sum_n  = (cnt == '0) ? SUM_W'(bin_data) : run_sum + SUM_W'(bin_data);
    peak_n = run_peak;
    idx_n  = run_idx;
    if (cnt == '0 || bin_data > run_peak) begin
      peak_n = bin_data;
      idx_n  = cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      run_sum   <= '0;
      run_peak  <= '0;
      run_idx   <= '0;
      total     <= '0;
      peak_val  <= '0;
      peak_idx  <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
      rd_data   <= '0;
    end else if (ena) begin
      rd_data <= bin_mem[rd_addr];
      if (cap_beat) begin
        cnt      <= (bin_last || at_end) ? '0 : cnt + 1'b1;
        run_sum  <= sum_n;
        run_peak <= peak_n;
        run_idx  <= idx_n;
      end
      if (good) begin
        total     <= sum_n;
        peak_val  <= peak_n;
        peak_idx  <= idx_n;
        frame_cnt <= frame_cnt + 1'b1;
      end
      // A set in the same cycle as ack wins
      frame_err <= err_set || (frame_err && !ack);
      overrun   <= drop || (overrun && !ack);
    end
  end

  // Buffer has no reset; only valid once a frame is held
  always_ff @(posedge clk) begin
    if (ena && cap_beat) bin_mem[cnt] <= bin_data;
  end

endmodule

// File: tb/tb_hist_dump_receiver.sv
// Randomized bench for hist_dump_receiver against a frame-level queue model.
module tb_hist_dump_receiver;
  localparam int N = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [3:0] bin_data = '0;
  logic       bin_valid = 1'b0;
  logic       bin_last = 1'b0;
  logic       ack = 1'b0;
  logic [4:0] rd_addr = '0;
  logic [3:0] rd_data;
  logic       frame_ready;
  logic [8:0] total;
  logic [3:0] peak_val;
  logic [4:0] peak_idx;
  logic       frame_err;
  logic       overrun;
  logic [7:0] frame_cnt;

  hist_dump_receiver dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bin_data(bin_data),
    .bin_valid(bin_valid), .bin_last(bin_last), .ack(ack),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_ready(frame_ready),
    .total(total), .peak_val(peak_val), .peak_idx(peak_idx),
    .frame_err(frame_err), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame-level view
  int   m_cur[$];
  int   m_held[N];
  bit   m_hold, m_disc, m_ferr, m_ovr;
  int   m_total, m_pval, m_pidx;
  logic [7:0] m_fcnt;
  bit   rd_chk;
  int   rd_exp;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic model();
    bit eset, oset;
    rd_chk = 1'b0;
    if (!rst_n) begin
      m_cur.delete();
      {m_hold, m_disc, m_ferr, m_ovr} = '0;
      m_total = 0; m_pval = 0; m_pidx = 0; m_fcnt = '0;
      rd_chk = 1'b1; rd_exp = 0;
      return;
    end
    if (!ena) return;
    if (m_hold) begin
      rd_chk = 1'b1;
      rd_exp = m_held[rd_addr];
    end
    eset = 0; oset = 0;
    if (m_hold) begin
      if (bin_valid) oset = 1;
      if (ack) m_hold = 0;
    end else if (m_disc) begin
      if (bin_valid && bin_last) m_disc = 0;
    end else if (bin_valid) begin
      m_cur.push_back(int'(bin_data));
      if (bin_last) begin
        if (m_cur.size() == N) begin
          m_total = 0; m_pval = -1;
          for (int i = 0; i < N; i++) begin
            m_held[i] = m_cur[i];
            m_total += m_cur[i];
            if (m_cur[i] > m_pval) begin m_pval = m_cur[i]; m_pidx = i; end
          end
          m_fcnt++;
          m_hold = 1;
        end else eset = 1;
        m_cur.delete();
      end else if (m_cur.size() == N) begin
        eset = 1; m_disc = 1;
        m_cur.delete();
      end
    end
    m_ferr = eset || (m_ferr && !ack);
    m_ovr  = oset || (m_ovr && !ack);
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("frame_ready", frame_ready, m_hold);
    chk("total", total, m_total);
    chk("peak_val", peak_val, m_pval);
    chk("peak_idx", peak_idx, m_pidx);
    chk("frame_err", frame_err, m_ferr);
    chk("overrun", overrun, m_ovr);
    chk("frame_cnt", frame_cnt, m_fcnt);
    if (rd_chk) chk("rd_data", rd_data, rd_exp);
    rd_addr = 5'($urandom_range(0, N-1));
  endtask

  task automatic cyc(input bit v, input int d, input bit l, input bit a, input bit e = 1'b1);
    bin_valid = v; bin_data = 4'(d); bin_last = l; ack = a; ena = e;
    step();
    bin_valid = 0; ack = 0; ena = 1;
  endtask

  // kind 0: i%16, 1: constant v, 2: random
  task automatic frame(input int n, input int kind, input int v, input int gap, input bit with_last);
    int d;
    for (int i = 0; i < n; i++) begin
      d = (kind == 0) ? i % 16 : (kind == 1) ? v : int'($urandom_range(0, 15));
      cyc(1, d, with_last && (i == n-1), 0);
      for (int g = 0; g < gap; g++) cyc(0, 0, 0, 0);
    end
  endtask

  initial begin
    // Reset
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("rst_total", total, 0);
    chk("rst_ready", frame_ready, 0);
    chk("rst_fcnt", frame_cnt, 0);
    rst_n = 1;
    cyc(0, 0, 0, 0);

    // Ramp frame
    frame(N, 0, 0, 0, 1);
    chk("ramp_ready", frame_ready, 1);
    chk("ramp_total", total, 240);
    chk("ramp_pval", peak_val, 15);
    chk("ramp_pidx", peak_idx, 15);
    chk("ramp_fcnt", frame_cnt, 1);
    rd_addr = 5'd20; bin_valid = 0; step();
    chk("ramp_rd20", rd_data, 4);
    cyc(0, 0, 0, 1);

    // Ties with gaps
    frame(N, 1, 7, 3, 1);
    chk("tie_total", total, 224);
    chk("tie_pval", peak_val, 7);
    chk("tie_pidx", peak_idx, 0);
    chk("tie_ready", frame_ready, 1);
    cyc(0, 0, 0, 1);

    // Short frame, then all ones
    frame(10, 2, 0, 0, 1);
    chk("short_err", frame_err, 1);
    chk("short_ready", frame_ready, 0);
    frame(N, 1, 1, 0, 1);
    chk("ones_total", total, 32);
    cyc(0, 0, 0, 1);
    chk("ack_clr_err", frame_err, 0);

    // Long frame then recovery
    frame(N, 2, 0, 0, 0);
    chk("long_err", frame_err, 1);
    frame(5, 2, 0, 1, 1);
    frame(N, 2, 0, 0, 1);
    chk("long_recover", frame_ready, 1);

    // Overrun in hold
    cyc(1, 3, 0, 0); cyc(1, 9, 1, 0);
    chk("ovr_set", overrun, 1);
    cyc(0, 0, 0, 1);
    chk("ovr_clr", overrun, 0);
    chk("ovr_ready", frame_ready, 0);
    frame(N, 2, 0, 0, 1);
    cyc(1, 5, 0, 1);
    chk("ovr_ack_beat", overrun, 1);
    frame(N, 0, 0, 0, 1);
    chk("after_ack_beat", total, 240);
    cyc(0, 0, 0, 1);

    // Reset mid-frame
    frame(12, 2, 0, 0, 0);
    rst_n = 0; cyc(1, 4, 0, 0); rst_n = 1;
    chk("midrst_fcnt", frame_cnt, 0);
    chk("midrst_total", total, 0);
    frame(N, 2, 0, 0, 1);
    chk("midrst_fcnt1", frame_cnt, 1);
    cyc(0, 0, 0, 1);

    // Enable low mid-frame
    frame(5, 2, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 15, 1, 0, 0);
    frame(N-5, 2, 0, 0, 1);
    chk("ena_ready", frame_ready, 1);
    cyc(0, 0, 0, 1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      bin_valid = ($urandom_range(0, 99) < 70);
      bin_data  = 4'($urandom_range(0, 15));
      bin_last  = (m_cur.size() == N-1) ? ($urandom_range(0, 99) < 85)
                                         : ($urandom_range(0, 99) < 3);
      ack       = ($urandom_range(0, 99) < 5);
      ena       = ($urandom_range(0, 99) < 90);
      rst_n     = ($urandom_range(0, 999) >= 2);
      step();
    end
    rst_n = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
